uart_baud_gen: RTL and testbench

//   Parametrised baud timing generator shared by UART TX and RX. A fractional

---
 rtl/uart_baud_gen_if.sv | 31 +++
 rtl/uart_baud_gen.sv | 147 ++++++++++++++
 tb/tb_uart_baud_gen.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_baud_gen_if.sv
// Signal bundle between the shared baud timing generator and the UART TX/RX
// blocks that consume its ticks.
interface uart_baud_gen_if;
   logic       enable;
   logic [2:0] baud_select;
   logic       resync;
   logic       sample_tick;
   logic       mid_tick;
   logic       bit_tick;
   logic [2:0] baud_active;

   modport master (
      output enable,
      output baud_select,
      output resync,
      input  sample_tick,
      input  mid_tick,
      input  bit_tick,
      input  baud_active
   );

   modport slave (
      input  enable,
      input  baud_select,
      input  resync,
      output sample_tick,
      output mid_tick,
      output bit_tick,
      output baud_active
   );
endinterface

// File: rtl/uart_baud_gen.sv
// Fractional-NCO baud timing generator: oversampled sample tick plus bit-centre
// and bit-end ticks, with boundary-aligned rate changes and start-edge resync.
module uart_baud_gen #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int OVERSAMPLE = 16,
   parameter int ACC_W      = 24
) (
   input  logic           clk,
   input  logic           rst,
   uart_baud_gen_if.slave bus
);

   localparam int SUB_W = $clog2(OVERSAMPLE);
   localparam logic [SUB_W-1:0] SUB_MID  = SUB_W'(OVERSAMPLE / 2 - 1);
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVERSAMPLE - 1);
   localparam longint unsigned ACC_MOD = 64'd1 << ACC_W;

   function automatic longint unsigned baud_of(input logic [2:0] sel);
      longint unsigned b;
      case (sel)
         3'd0:    b = 64'd300;
         3'd1:    b = 64'd1200;
         3'd2:    b = 64'd4800;
         3'd3:    b = 64'd9600;
         3'd4:    b = 64'd19200;
         3'd5:    b = 64'd38400;
         3'd6:    b = 64'd57600;
         default: b = 64'd115200;
      endcase
      return b;
   endfunction

   function automatic longint unsigned calc_inc(input logic [2:0] sel);
      longint unsigned num;
      num = baud_of(sel) * 64'(OVERSAMPLE) * ACC_MOD;
      return (num + 64'(CLK_HZ) / 64'd2) / 64'(CLK_HZ);
   endfunction

   function automatic bit inc_table_ok();
      longint unsigned inc;
      for (int s = 0; s < 8; s++) begin
         inc = calc_inc(3'(s));
         if (inc == 64'd0 || inc >= ACC_MOD) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic logic [7:0][ACC_W-1:0] build_tab();
      logic [7:0][ACC_W-1:0] t;
      for (int s = 0; s < 8; s++) t[s] = ACC_W'(calc_inc(3'(s)));
      return t;
   endfunction

   localparam bit                    INC_OK  = inc_table_ok();
   localparam logic [7:0][ACC_W-1:0] INC_TAB = build_tab();

   if (OVERSAMPLE < 4 || OVERSAMPLE > 64 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
      $error("uart_baud_gen: OVERSAMPLE must be even and in 4..64");
   end
   if (!INC_OK) begin : g_bad_inc
      $error("uart_baud_gen: increment table has a zero or overflowing entry");
   end

   logic [ACC_W-1:0] acc_p0;
   logic [SUB_W-1:0] sub_cnt_p0;
   logic             en_d;
   logic             pend;
   logic [2:0]       pend_sel;
   logic [2:0]       baud_active_q;
   logic             sample_p1;
   logic             mid_p1;
   logic             bit_p1;

   logic [ACC_W-1:0] inc_sel;
   logic [ACC_W:0]   sum_p0;
   logic             carry_p0;
   logic             restart;
   logic             gen_mid;
   logic             gen_bit;
   logic             apply;
   logic [2:0]       active_nxt;

   // Stage p0: phase add and tick decode
   always_comb begin
      inc_sel    = INC_TAB[baud_active_q];
      sum_p0     = {1'b0, acc_p0} + {1'b0, inc_sel};
      carry_p0   = sum_p0[ACC_W];
      // A rising enable restarts the phase exactly like a resync pulse.
      restart    = !bus.enable || bus.resync || !en_d;
      gen_mid    = carry_p0 && (sub_cnt_p0 == SUB_MID);
      gen_bit    = carry_p0 && (sub_cnt_p0 == SUB_LAST);
      apply      = gen_bit && pend && !restart;
      active_nxt = apply ? pend_sel : baud_active_q;
   end

   // Stage p1: registered ticks and phase state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_p0     <= '0;
         sub_cnt_p0 <= '0;
         en_d       <= 1'b0;
         sample_p1  <= 1'b0;
         mid_p1     <= 1'b0;
         bit_p1     <= 1'b0;
      end else begin
         en_d <= bus.enable;
         if (restart) begin
            acc_p0     <= '0;
            sub_cnt_p0 <= '0;
            sample_p1  <= 1'b0;
            mid_p1     <= 1'b0;
            bit_p1     <= 1'b0;
         end else begin
            acc_p0    <= sum_p0[ACC_W-1:0];
            sample_p1 <= carry_p0;
            mid_p1    <= gen_mid;
            bit_p1    <= gen_bit;
            if (carry_p0) begin
               sub_cnt_p0 <= (sub_cnt_p0 == SUB_LAST) ? '0 : sub_cnt_p0 + 1'b1;
            end
         end
      end
   end

   // Newest request is held until the add that produces a bit end.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         baud_active_q <= 3'd0;
         pend          <= 1'b0;
         pend_sel      <= 3'd0;
      end else if (!bus.enable) begin
         baud_active_q <= bus.baud_select;
         pend          <= 1'b0;
         pend_sel      <= bus.baud_select;
      end else begin
         baud_active_q <= active_nxt;
         pend          <= (bus.baud_select != active_nxt);
         pend_sel      <= bus.baud_select;
      end
   end

   assign bus.sample_tick = sample_p1;
   assign bus.mid_tick    = mid_p1;
   assign bus.bit_tick    = bit_p1;
   assign bus.baud_active = baud_active_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Self-checking bench for uart_baud_gen: ideal-phase model compared every
// cycle, plus directed timing checks at 9600 and 115200 baud.
module tb_uart_baud_gen;
   localparam int OS    = 16;
   localparam int ACC_W = 24;

   logic clk = 1'b0;
   logic rst = 1'b1;

   uart_baud_gen_if bus ();

   uart_baud_gen #(
      .CLK_HZ    (50_000_000),
      .OVERSAMPLE(OS),
      .ACC_W     (ACC_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: unbounded phase since last restart; tick k fires when phase/2^W reaches k.
   longint unsigned m_ph      = 0;
   int              m_req     = -1;
   logic            m_en_prev = 1'b0;
   logic            exp_s     = 1'b0;
   logic            exp_m     = 1'b0;
   logic            exp_b     = 1'b0;
   logic [2:0]      exp_act   = 3'd0;

   longint unsigned n_ph;
   longint unsigned n_k;
   logic            n_s, n_m, n_b;
   logic [2:0]      n_act;
   int              n_req;

   function automatic longint unsigned model_inc(input logic [2:0] sel);
      longint unsigned baud;
      case (sel)
         3'd0:    baud = 300;
         3'd1:    baud = 1200;
         3'd2:    baud = 4800;
         3'd3:    baud = 9600;
         3'd4:    baud = 19200;
         3'd5:    baud = 38400;
         3'd6:    baud = 57600;
         default: baud = 115200;
      endcase
      return (baud * 64'(OS) * (64'd1 << ACC_W) + 64'd25_000_000) / 64'd50_000_000;
   endfunction

   always_comb begin
      n_s  = 1'b0;
      n_m  = 1'b0;
      n_b  = 1'b0;
      n_ph = 0;
      n_k  = 0;
      if (bus.enable && !bus.resync && m_en_prev) begin
         n_ph = m_ph + model_inc(exp_act);
         n_k  = n_ph >> ACC_W;
         if (n_k != (m_ph >> ACC_W)) begin
            n_s = 1'b1;
            n_m = ((n_k % 64'(OS)) == 64'(OS / 2));
            n_b = ((n_k % 64'(OS)) == 64'd0);
         end
      end
      n_act = exp_act;
      if (!bus.enable) n_act = bus.baud_select;
      else if (n_b && m_req >= 0) n_act = 3'(m_req);
      n_req = (bus.enable && bus.baud_select != n_act) ? int'(bus.baud_select) : -1;
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ph      <= 0;
         m_req     <= -1;
         m_en_prev <= 1'b0;
         exp_s     <= 1'b0;
         exp_m     <= 1'b0;
         exp_b     <= 1'b0;
         exp_act   <= 3'd0;
      end else begin
         m_ph      <= n_ph;
         m_req     <= n_req;
         m_en_prev <= bus.enable;
         exp_s     <= n_s;
         exp_m     <= n_m;
         exp_b     <= n_b;
         exp_act   <= n_act;
      end
   end

   int cyc_n = 0;
   int cnt_s, cnt_m, cnt_b, last_s, gmin, gmax, tick_idx, mid_bad;

   task automatic clr_stats();
      cnt_s = 0; cnt_m = 0; cnt_b = 0; last_s = -1;
      gmin = 1_000_000; gmax = 0; tick_idx = 0; mid_bad = 0;
   endtask

   task automatic chk(input string name, input longint act, input longint lo, input longint hi);
      checks++;
      if (act < lo || act > hi) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic chk_zero(input string name);
      checks++;
      if ({bus.sample_tick, bus.mid_tick, bus.bit_tick, bus.baud_active} !== 6'b0) begin
         errors++;
         $display("FAIL %s: got s/m/b=%b%b%b act=%b, required all zero", name,
                  bus.sample_tick, bus.mid_tick, bus.bit_tick, bus.baud_active);
      end
   endtask

   task automatic step();
      int gap;
      @(negedge clk);
      cyc_n++;
      checks++;
      if ({bus.sample_tick, bus.mid_tick, bus.bit_tick, bus.baud_active} !==
          {exp_s, exp_m, exp_b, exp_act}) begin
         errors++;
         $display("FAIL model cycle %0d: got s/m/b=%b%b%b act=%0d, required s/m/b=%b%b%b act=%0d",
                  cyc_n, bus.sample_tick, bus.mid_tick, bus.bit_tick, bus.baud_active,
                  exp_s, exp_m, exp_b, exp_act);
      end
      if (bus.sample_tick === 1'b1) begin
         cnt_s++;
         tick_idx++;
         if (last_s >= 0) begin
            gap = cyc_n - last_s;
            if (gap < gmin) gmin = gap;
            if (gap > gmax) gmax = gap;
         end
         last_s = cyc_n;
         if (bus.mid_tick === 1'b1 && (tick_idx % OS) != OS / 2) mid_bad++;
      end
      if (bus.mid_tick === 1'b1) cnt_m++;
      if (bus.bit_tick === 1'b1) cnt_b++;
   endtask

   task automatic wait_ev(input string name, input int which, input int bound, output int t);
      bit found;
      t = 0;
      found = 1'b0;
      while (!found && t < bound) begin
         step();
         t++;
         case (which)
            0:       found = (bus.sample_tick === 1'b1);
            1:       found = (bus.mid_tick === 1'b1);
            2:       found = (bus.bit_tick === 1'b1);
            default: found = (bus.baud_active === 3'd3);
         endcase
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL %s: no event within %0d cycles", name, bound);
      end
   endtask

   initial begin
      int t, t2;
      logic [2:0] prev;
      bus.enable      = 1'b0;
      bus.baud_select = 3'd3;
      bus.resync      = 1'b0;
      clr_stats();

      step();
      step();
      chk_zero("reset_state");
      rst = 1'b0;
      repeat (3) step();
      chk("idle_act_follows_sel", bus.baud_active, 3, 3);

      // 9600 baud steady state
      clr_stats();
      bus.enable = 1'b1;
      repeat (20000) step();
      chk("9600_samples", cnt_s, 60, 62);
      chk("9600_mids", cnt_m, 4, 4);
      chk("9600_bits", cnt_b, 3, 3);
      chk("9600_gap_min", gmin, 325, 325);
      chk("9600_gap_max", gmax, 326, 326);

      // 115200 baud steady state
      bus.enable      = 1'b0;
      bus.baud_select = 3'd7;
      step();
      chk("idle_act_115200", bus.baud_active, 7, 7);
      clr_stats();
      bus.enable = 1'b1;
      repeat (16384) step();
      chk("115200_samples", cnt_s, 602, 605);
      chk("115200_gap_min", gmin, 27, 27);
      chk("115200_gap_max", gmax, 28, 28);
      chk("115200_mids", cnt_m, 37, 38);
      chk("115200_bits", cnt_b, 37, 38);
      chk("115200_mid_is_8th", mid_bad, 0, 0);

      // rate change mid-bit 9600 -> 115200
      bus.enable      = 1'b0;
      bus.baud_select = 3'd3;
      step();
      bus.enable = 1'b1;
      wait_ev("rate_first_bit", 2, 6000, t);
      repeat (100) step();
      bus.baud_select = 3'd7;
      prev = bus.baud_active;
      t = 0;
      while (bus.bit_tick !== 1'b1 && t < 6000) begin
         prev = bus.baud_active;
         step();
         t++;
      end
      chk("rate_bit_reached", t, 1, 5999);
      chk("rate_act_before_bit", prev, 3, 3);
      chk("rate_act_at_bit", bus.baud_active, 7, 7);
      wait_ev("rate_gap", 0, 100, t);
      chk("rate_gap_after_change", t, 27, 28);

      // resync 100 clk after a bit end at 9600
      bus.baud_select = 3'd3;
      wait_ev("resync_back_to_9600", 3, 2000, t);
      wait_ev("resync_bit", 2, 6000, t);
      repeat (100) step();
      bus.resync = 1'b1;
      step();
      bus.resync = 1'b0;
      chk("resync_no_tick", bus.sample_tick, 0, 0);
      wait_ev("resync_mid", 1, 3000, t);
      chk("resync_mid_delay", t + 1, 2604, 2608);
      wait_ev("resync_bit_after", 2, 3000, t2);
      chk("resync_bit_delay", t + 1 + t2, 5208, 5212);

      // enable low beats resync; re-enable restarts the phase
      bus.enable = 1'b0;
      bus.resync = 1'b1;
      clr_stats();
      step();
      bus.baud_select = 3'd5;
      step();
      chk("disabled_act_follows_5", bus.baud_active, 5, 5);
      bus.baud_select = 3'd3;
      step();
      chk("disabled_act_follows_3", bus.baud_active, 3, 3);
      repeat (3) step();
      chk("disabled_no_ticks", cnt_s + cnt_m + cnt_b, 0, 0);
      bus.enable = 1'b1;
      bus.resync = 1'b0;
      wait_ev("reenable_first", 0, 400, t);
      chk("reenable_first_sample", t, 325, 328);

      // asynchronous reset in the middle of a run
      repeat (500) step();
      #2 rst = 1'b1;
      #1 chk_zero("async_reset_drop");
      step();
      step();
      rst = 1'b0;
      wait_ev("post_reset_first", 0, 10600, t);
      chk("post_reset_first_sample", t, 10415, 10420);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
